// File: rtl/pdp8_uart_pkg.sv
// Shared constants for the console TT serial line: frame geometry, mid-bit
// sample phases and the state encodings of the transmit and receive machines.
package pdp8_uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] START_MID = 4'd7;
  localparam logic [3:0] BIT_MID   = 4'd15;

  typedef logic [1:0] txState_t;
  localparam txState_t TX_IDLE  = 2'd0;
  localparam txState_t TX_START = 2'd1;
  localparam txState_t TX_DATA  = 2'd2;
  localparam txState_t TX_STOP  = 2'd3;

  typedef logic [2:0] rxState_t;
  localparam rxState_t RX_IDLE  = 3'd0;
  localparam rxState_t RX_START = 3'd1;
  localparam rxState_t RX_DATA  = 3'd2;
  localparam rxState_t RX_STOP  = 3'd3;
  localparam rxState_t RX_BREAK = 3'd4;

endpackage

// File: rtl/pdp8_uart_rx.sv
// Receive path: input synchroniser, oversampled 8N1 deserialiser and the
// holding register. o_done pulses combinationally on the edge rx_hold loads.
module pdp8_uart_rx
  import pdp8_uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rxClk,
  input  logic                 i_rxIn,
  output logic [DATA_BITS-1:0] o_hold,
  output logic                 o_done
);

  logic                 r_sync1;
  logic                 r_sync2;
  rxState_t             r_state;
  logic [3:0]           r_phase;
  logic [2:0]           r_bitCnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_hold;
  logic                 w_line;

  assign w_line = r_sync2;
  assign o_hold = r_hold;
  assign o_done = i_rxClk && (r_state == RX_STOP) && (r_phase == BIT_MID) && w_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_state  <= RX_IDLE;
      r_phase  <= 4'd0;
      r_bitCnt <= 3'd0;
      r_shift  <= '0;
      r_hold   <= '0;
    end else begin
      r_sync1 <= i_rxIn;
      r_sync2 <= r_sync1;
      if (i_rxClk) begin
        case (r_state)
          RX_IDLE: begin
            if (!w_line) begin
              r_state <= RX_START;
              r_phase <= 4'd0;
            end
          end
          // A start bit that is high again at its middle was only a glitch.
          RX_START: begin
            if (r_phase == START_MID) begin
              if (w_line) begin
                r_state <= RX_IDLE;
              end else begin
                r_state  <= RX_DATA;
                r_phase  <= 4'd0;
                r_bitCnt <= 3'd0;
              end
            end else begin
              r_phase <= r_phase + 4'd1;
            end
          end
          RX_DATA: begin
            r_phase <= r_phase + 4'd1;
            if (r_phase == BIT_MID) begin
              r_shift  <= {w_line, r_shift[DATA_BITS-1:1]};
              r_bitCnt <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) begin
                r_state <= RX_STOP;
              end
            end
          end
          RX_STOP: begin
            r_phase <= r_phase + 4'd1;
            if (r_phase == BIT_MID) begin
              if (w_line) begin
                r_hold  <= r_shift;
                r_state <= RX_IDLE;
              end else begin
                r_state <= RX_BREAK;
              end
            end
          end
          RX_BREAK: begin
            if (w_line) begin
              r_state <= RX_IDLE;
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/pdp8_uart.sv
// Console TT serial-line UART: transmit holding register and 8N1 shifter,
// plus the req/ack handshakes towards the console device controller.
module pdp8_uart
  import pdp8_uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_clk,
  input  logic                 tx_req,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ack,
  output logic                 tx_empty,
  input  logic                 rx_clk,
  input  logic                 rx_req,
  output logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  input  logic                 rx_in,
  output logic                 tx_out
);

  logic                 r_txHoldFull;
  logic [DATA_BITS-1:0] r_txHold;
  logic [DATA_BITS-1:0] r_txShift;
  logic [2:0]           r_txBitCnt;
  txState_t             r_txState;
  logic                 r_txOut;
  logic                 r_txAck;

  logic                 r_rxAck;
  logic [DATA_BITS-1:0] r_rxData;
  logic                 r_rxEmpty;
  logic [DATA_BITS-1:0] w_rxHold;
  logic                 w_rxDone;

  assign tx_out   = r_txOut;
  assign tx_ack   = r_txAck;
  assign tx_empty = !r_txHoldFull && (r_txState == TX_IDLE);
  assign rx_ack   = r_rxAck;
  assign rx_data  = r_rxData;
  assign rx_empty = r_rxEmpty;

  // Handshake fill and shifter load never coincide: one needs the holding
  // register empty, the other needs it full.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_txHoldFull <= 1'b0;
      r_txHold     <= '0;
      r_txShift    <= '0;
      r_txBitCnt   <= 3'd0;
      r_txState    <= TX_IDLE;
      r_txOut      <= 1'b1;
      r_txAck      <= 1'b0;
    end else begin
      if (!tx_req) begin
        r_txAck <= 1'b0;
      end else if (!r_txAck && !r_txHoldFull) begin
        r_txHold     <= tx_data;
        r_txHoldFull <= 1'b1;
        r_txAck      <= 1'b1;
      end
      if (tx_clk) begin
        case (r_txState)
          // Leaving STOP straight into START keeps back-to-back frames gapless.
          TX_IDLE, TX_STOP: begin
            if (r_txHoldFull) begin
              r_txShift    <= r_txHold;
              r_txHoldFull <= 1'b0;
              r_txOut      <= 1'b0;
              r_txState    <= TX_START;
            end else begin
              r_txState <= TX_IDLE;
            end
          end
          TX_START: begin
            r_txOut    <= r_txShift[0];
            r_txShift  <= r_txShift >> 1;
            r_txBitCnt <= 3'd0;
            r_txState  <= TX_DATA;
          end
          TX_DATA: begin
            if (r_txBitCnt == 3'd7) begin
              r_txOut   <= 1'b1;
              r_txState <= TX_STOP;
            end else begin
              r_txOut    <= r_txShift[0];
              r_txShift  <= r_txShift >> 1;
              r_txBitCnt <= r_txBitCnt + 3'd1;
            end
          end
          default: r_txState <= TX_IDLE;
        endcase
      end
    end
  end

  pdp8_uart_rx u_rx (
    .clk     (clk),
    .reset   (reset),
    .i_rxClk (rx_clk),
    .i_rxIn  (rx_in),
    .o_hold  (w_rxHold),
    .o_done  (w_rxDone)
  );

  // A frame finishing on the handshake edge still marks the holding register
  // full; the handshake itself hands over the previous byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxAck   <= 1'b0;
      r_rxData  <= '0;
      r_rxEmpty <= 1'b1;
    end else begin
      if (!rx_req) begin
        r_rxAck <= 1'b0;
      end else if (!r_rxAck) begin
        r_rxData  <= w_rxHold;
        r_rxAck   <= 1'b1;
        r_rxEmpty <= 1'b1;
      end
      if (w_rxDone) begin
        r_rxEmpty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdp8_uart.sv
// Directed bench for pdp8_uart: TX framing and handshake, RX framing, glitch,
// framing error, overrun and mid-frame reset, with hand-computed expectations.
module tb_pdp8_uart;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_clk;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       tx_empty;
  logic       rx_clk;
  logic       rx_req;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_in;
  logic       tx_out;

  int total = 0;
  int bad   = 0;

  pdp8_uart dut (
    .clk      (clk),
    .reset    (reset),
    .tx_clk   (tx_clk),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .tx_empty (tx_empty),
    .rx_clk   (rx_clk),
    .rx_req   (rx_req),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_empty (rx_empty),
    .rx_in    (rx_in),
    .tx_out   (tx_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One bit period: tx_clk high for one edge, then three quiet edges.
  task automatic txFrame(input string tag, input logic [7:0] data, input int firstIdx);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int i = firstIdx; i < 10; i++) begin
      tx_clk = 1'b1;
      step();
      tx_clk = 1'b0;
      checkOutput($sformatf("%s_bit%0d", tag, i), {7'd0, tx_out}, {7'd0, frame[i]});
      checkOutput($sformatf("%s_busy%0d", tag, i), {7'd0, tx_empty}, 8'd0);
      repeat (3) step();
    end
  endtask

  task automatic txIdleTick(input string tag);
    tx_clk = 1'b1;
    step();
    tx_clk = 1'b0;
    checkOutput({tag, "_empty"}, {7'd0, tx_empty}, 8'd1);
    checkOutput({tag, "_line"}, {7'd0, tx_out}, 8'd1);
    repeat (3) step();
  endtask

  task automatic txWrite(input string tag, input logic [7:0] data);
    tx_data = data;
    tx_req  = 1'b1;
    step();
    checkOutput({tag, "_ack"}, {7'd0, tx_ack}, 8'd1);
    checkOutput({tag, "_notempty"}, {7'd0, tx_empty}, 8'd0);
    tx_req = 1'b0;
    step();
    checkOutput({tag, "_ackdrop"}, {7'd0, tx_ack}, 8'd0);
  endtask

  // Serial frame on rx_in at 16 clocks per bit (rx_clk is held high).
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_in = frame[b];
      repeat (16) step();
    end
    rx_in = 1'b1;
  endtask

  task automatic rxRead(input string tag, input logic [7:0] expData);
    rx_req = 1'b1;
    step();
    checkOutput({tag, "_ack"}, {7'd0, rx_ack}, 8'd1);
    checkOutput({tag, "_data"}, rx_data, expData);
    checkOutput({tag, "_empty"}, {7'd0, rx_empty}, 8'd1);
    rx_req = 1'b0;
    step();
    checkOutput({tag, "_ackdrop"}, {7'd0, rx_ack}, 8'd0);
  endtask

  initial begin
    reset   = 1'b1;
    tx_clk  = 1'b0;
    tx_req  = 1'b0;
    tx_data = 8'h00;
    rx_clk  = 1'b1;
    rx_req  = 1'b0;
    rx_in   = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();

    checkOutput("rst_txout", {7'd0, tx_out}, 8'd1);
    checkOutput("rst_txack", {7'd0, tx_ack}, 8'd0);
    checkOutput("rst_txempty", {7'd0, tx_empty}, 8'd1);
    checkOutput("rst_rxack", {7'd0, rx_ack}, 8'd0);
    checkOutput("rst_rxempty", {7'd0, rx_empty}, 8'd1);
    checkOutput("rst_rxdata", rx_data, 8'h00);

    $display("[TB] single TX byte 0x55");
    txWrite("t1", 8'h55);
    txFrame("t1", 8'h55, 0);
    txIdleTick("t1_end");

    $display("[TB] back-to-back TX 0x41 / 0x42");
    txWrite("t2a", 8'h41);
    tx_data = 8'h42;
    tx_req  = 1'b1;
    step();
    checkOutput("t2_ackwait0", {7'd0, tx_ack}, 8'd0);
    step();
    checkOutput("t2_ackwait1", {7'd0, tx_ack}, 8'd0);
    tx_clk = 1'b1;
    step();
    tx_clk = 1'b0;
    checkOutput("t2a_bit0", {7'd0, tx_out}, 8'd0);
    checkOutput("t2_ackwait2", {7'd0, tx_ack}, 8'd0);
    step();
    checkOutput("t2b_ack", {7'd0, tx_ack}, 8'd1);
    tx_req = 1'b0;
    step();
    checkOutput("t2b_ackdrop", {7'd0, tx_ack}, 8'd0);
    step();
    txFrame("t2a", 8'h41, 1);
    txFrame("t2b", 8'h42, 0);
    txIdleTick("t2_end");

    $display("[TB] RX 0xA3 then 0x10");
    checkOutput("t3_preempty", {7'd0, rx_empty}, 8'd1);
    applyStimulus(8'hA3, 1'b1);
    checkOutput("t3_full", {7'd0, rx_empty}, 8'd0);
    rxRead("t3a", 8'hA3);
    applyStimulus(8'h10, 1'b1);
    checkOutput("t3_hold_data", rx_data, 8'hA3);
    checkOutput("t3_full2", {7'd0, rx_empty}, 8'd0);
    rxRead("t3b", 8'h10);

    $display("[TB] RX glitch and framing error");
    rx_in = 1'b0;
    repeat (4) step();
    rx_in = 1'b1;
    repeat (40) step();
    checkOutput("t4_glitch", {7'd0, rx_empty}, 8'd1);
    applyStimulus(8'h66, 1'b0);
    repeat (20) step();
    checkOutput("t4_frameerr", {7'd0, rx_empty}, 8'd1);
    applyStimulus(8'h7E, 1'b1);
    checkOutput("t4_full", {7'd0, rx_empty}, 8'd0);
    rxRead("t4", 8'h7E);

    $display("[TB] RX overrun");
    applyStimulus(8'h31, 1'b1);
    applyStimulus(8'h32, 1'b1);
    checkOutput("t5_full", {7'd0, rx_empty}, 8'd0);
    rxRead("t5", 8'h32);

    $display("[TB] reset mid-frame");
    txWrite("t6pre", 8'h5A);
    for (int i = 0; i < 24; i++) begin
      tx_clk = (i % 4 == 0);
      rx_in  = 1'b0;
      step();
    end
    tx_clk = 1'b0;
    checkOutput("t6_midbusy", {7'd0, tx_empty}, 8'd0);
    rx_in = 1'b1;
    reset = 1'b1;
    step();
    checkOutput("t6_txout", {7'd0, tx_out}, 8'd1);
    checkOutput("t6_txempty", {7'd0, tx_empty}, 8'd1);
    checkOutput("t6_rxempty", {7'd0, rx_empty}, 8'd1);
    checkOutput("t6_txack", {7'd0, tx_ack}, 8'd0);
    checkOutput("t6_rxack", {7'd0, rx_ack}, 8'd0);
    checkOutput("t6_rxdata", rx_data, 8'h00);
    reset = 1'b0;
    repeat (4) step();
    txWrite("t6", 8'h5A);
    txFrame("t6", 8'h5A, 0);
    txIdleTick("t6_end");
    applyStimulus(8'h5A, 1'b1);
    checkOutput("t6_rxfull", {7'd0, rx_empty}, 8'd0);
    rxRead("t6", 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
